alu_cmd_sequencer: RTL and testbench

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu.sv | 33 +++
 rtl/alu_cmd_sequencer.sv | 131 +++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU widths, op-code constants and sequencer FSM encoding.
// Pure declarations: no latency, no flow control.
package alu_pkg;

  localparam int DATA_W = 4;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_NOT = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

  // Codes 110 and 111 are the only undefined operations.
  function automatic logic op_illegal(input logic [OP_W-1:0] op);
    return op[2:1] == 2'b11;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 4-bit ALU: add/sub with carry-borrow, bitwise logic, NOT a.
// Zero latency; no flow control.
module alu
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
      OP_SUB: begin
        result = a - b;
        carry  = (a < b);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands in a DEPTH-entry FIFO and returns one registered result per command.
// Result valid two edges after accept into an idle block; cmd_ready drops when full, result held until res_ready.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_carry,
  output logic              res_err,
  output logic              busy,
  output logic [7:0]        done_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  state_e state;
  state_e state_nxt;
  cmd_t   cur;

  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              cur_illegal;

  assign fifo_empty = (count == '0);
  assign cmd_ready  = (count < (AW+1)'(DEPTH));
  assign push       = cmd_valid & cmd_ready;
  assign res_valid  = (state == ST_RESP);
  assign busy       = (state != ST_IDLE) || !fifo_empty;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: begin
        if (res_ready) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = ST_EXEC;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Storage carries no reset; entries are only visible through count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cur <= '0;
    else if (pop) cur <= mem[rd_ptr];
  end

  alu u_alu (
    .a      (cur.a),
    .b      (cur.b),
    .op     (cur.op),
    .result (alu_result),
    .carry  (alu_carry)
  );

  assign cur_illegal = op_illegal(cur.op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data  <= '0;
      res_carry <= 1'b0;
      res_err   <= 1'b0;
    end else if (state == ST_EXEC) begin
      res_data  <= cur_illegal ? '0 : alu_result;
      res_carry <= cur_illegal ? 1'b0 : alu_carry;
      res_err   <= cur_illegal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              done_cnt <= '0;
    else if (state == ST_RESP && res_ready)  done_cnt <= done_cnt + 8'd1;
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench: stimulus queues expected {err,carry,data}; a negedge monitor checks each consumed result.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [3:0] cmd_a = '0;
  logic [3:0] cmd_b = '0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [3:0] res_data;
  logic       res_carry;
  logic       res_err;
  logic       busy;
  logic [7:0] done_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  logic [5:0] sb_q[$];

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_carry (res_carry),
    .res_err   (res_err),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] res(input logic [3:0] data, input logic carry, input logic err);
    return {err, carry, data};
  endfunction

  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL result_unexpected: actual 0x%0h required no result", {res_err, res_carry, res_data});
      end else begin
        check("result", {26'd0, res_err, res_carry, res_data}, {26'd0, sb_q.pop_front()});
      end
    end
  end

  // All stimulus runs in the phase just after a rising edge.
  task automatic push(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic [5:0] exp, input bit expect_it);
    int t = 0;
    while (!cmd_ready && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    if (!cmd_ready) begin
      check("push_timeout", 32'd1, 32'd0);
      return;
    end
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    if (expect_it) sb_q.push_back(exp);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb_q.size() != 0 || busy) && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_timeout", {31'd0, (t >= 3000)}, 32'd0);
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [4:0] sum;

    // Reset values while held in reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_data",  {28'd0, res_data},  32'd0);
    check("rst_res_carry", {31'd0, res_carry}, 32'd0);
    check("rst_res_err",   {31'd0, res_err},   32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_done_cnt",  {24'd0, done_cnt},  32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Latency: accept at E0, res_valid visible after E2
    res_ready = 1'b1;
    cmd_op = 3'b000; cmd_a = 4'b0101; cmd_b = 4'b0011; cmd_valid = 1'b1;
    sb_q.push_back(res(4'b1000, 1'b0, 1'b0));
    @(posedge clk); #1 cmd_valid = 1'b0;
    check("lat_e0_valid", {31'd0, res_valid}, 32'd0);
    check("lat_e0_busy",  {31'd0, busy},      32'd1);
    @(posedge clk); #1;
    check("lat_e1_valid", {31'd0, res_valid}, 32'd0);
    @(posedge clk); #1;
    check("lat_e2_valid", {31'd0, res_valid}, 32'd1);
    drain();

    push(3'b110, 4'b1111, 4'b1111, res(4'b0000, 1'b0, 1'b1), 1'b1);
    push(3'b111, 4'b0101, 4'b0011, res(4'b0000, 1'b0, 1'b1), 1'b1);
    push(3'b000, 4'b1111, 4'b0001, res(4'b0000, 1'b1, 1'b0), 1'b1);
    push(3'b001, 4'b0110, 4'b0010, res(4'b0100, 1'b0, 1'b0), 1'b1);
    push(3'b001, 4'b0010, 4'b0110, res(4'b1100, 1'b1, 1'b0), 1'b1);
    drain();
    check("done_after_6", {24'd0, done_cnt}, 32'd6);
    check("hold_valid",   {31'd0, res_valid}, 32'd0);
    check("hold_data",    {28'd0, res_data},  32'd12);
    check("hold_carry",   {31'd0, res_carry}, 32'd1);
    check("hold_err",     {31'd0, res_err},   32'd0);

    // Backpressure: one command in the FSM plus four queued fills the block
    do_reset();
    res_ready = 1'b0;
    push(3'b010, 4'b1100, 4'b1010, res(4'b1000, 1'b0, 1'b0), 1'b1);
    push(3'b011, 4'b1100, 4'b1010, res(4'b1110, 1'b0, 1'b0), 1'b1);
    push(3'b100, 4'b1100, 4'b1010, res(4'b0110, 1'b0, 1'b0), 1'b1);
    push(3'b101, 4'b1100, 4'b1010, res(4'b0011, 1'b0, 1'b0), 1'b1);
    check("ready_before_5th", {31'd0, cmd_ready}, 32'd1);
    push(3'b000, 4'b1100, 4'b1010, res(4'b0110, 1'b1, 1'b0), 1'b1);
    check("full_ready_low", {31'd0, cmd_ready}, 32'd0);
    check("full_res_valid", {31'd0, res_valid}, 32'd1);
    cmd_op = 3'b000; cmd_a = 4'b0001; cmd_b = 4'b0001; cmd_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("full_ignore_ready", {31'd0, cmd_ready}, 32'd0);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    cyc = 0;
    while (done_cnt != 8'd5 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("b2b_cycles", cyc, 32'd9);
    drain();
    check("done_after_5", {24'd0, done_cnt}, 32'd5);

    // Reset while in RESP with three commands queued
    res_ready = 1'b0;
    push(3'b000, 4'b0001, 4'b0001, '0, 1'b0);
    push(3'b000, 4'b0010, 4'b0001, '0, 1'b0);
    push(3'b000, 4'b0011, 4'b0001, '0, 1'b0);
    push(3'b000, 4'b0100, 4'b0001, '0, 1'b0);
    check("pre_rst_valid", {31'd0, res_valid}, 32'd1);
    check("pre_rst_done",  {24'd0, done_cnt},  32'd5);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, res_valid}, 32'd0);
    check("mid_rst_done",  {24'd0, done_cnt},  32'd0);
    check("mid_rst_busy",  {31'd0, busy},      32'd0);
    check("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("mid_rst_data",  {28'd0, res_data},  32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    res_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("post_rst_valid", {31'd0, res_valid}, 32'd0);
    check("post_rst_done",  {24'd0, done_cnt},  32'd0);

    // done_cnt wrap after 256 completions
    for (int i = 0; i < 255; i++) begin
      sum = {1'b0, i[3:0]} + 5'd3;
      push(3'b000, i[3:0], 4'd3, res(sum[3:0], sum[4], 1'b0), 1'b1);
    end
    drain();
    check("done_255", {24'd0, done_cnt}, 32'd255);
    push(3'b100, 4'b1010, 4'b0101, res(4'b1111, 1'b0, 1'b0), 1'b1);
    drain();
    check("done_wrap", {24'd0, done_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
